i2s_sample_fifo: RTL

Stereo sample buffer directly downstream of the I2S microphone receiver. It captures each left/right 16-bit sample pair on the receiver's one-cycle new-sample pulse and stores the pair as one entry. It presents the oldest entry to the processing datapath through a first-word-fall-through valid/ready interface, decoupling the fixed audio sample rate from downstream stalls. Overflow is detected, counted in a sticky flag, and never corrupts stored data.

---
 rtl/i2s_sample_fifo.sv | 79 +++++++
 1 files changed

// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO between the I2S receiver and the processing datapath.
// First-word-fall-through output, sticky overflow flag, drops never corrupt storage.
module i2s_sample_fifo #(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic [15:0]      left_sample_in,
  input  logic [15:0]      right_sample_in,
  input  logic             new_sample_in,
  output logic [15:0]      left_sample_out,
  output logic [15:0]      right_sample_out,
  output logic             sample_valid_out,
  input  logic             sample_ready_in,
  output logic [CNT_W-1:0] fill_count_out,
  output logic             overflow_out,
  input  logic             clear_overflow_in
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             valid;
  logic             push;
  logic             pop;
  logic             drop;
  logic [31:0]      head;

  assign valid = (count_q != '0);
  assign pop   = valid && sample_ready_in;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push  = new_sample_in && ((count_q != FULL) || pop);
  assign drop  = new_sample_in && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (drop)                   ovf_d = 1'b1;
    else if (clear_overflow_in) ovf_d = 1'b0;
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clock_in) begin
    if (push) mem_q[wr_ptr_q] <= {left_sample_in, right_sample_in};
  end

  assign head             = valid ? mem_q[rd_ptr_q] : 32'd0;
  assign left_sample_out  = head[31:16];
  assign right_sample_out = head[15:0];
  assign sample_valid_out = valid;
  assign fill_count_out   = count_q;
  assign overflow_out     = ovf_q;

endmodule
